// File: rtl/disp_serial_capture_if.sv
// Display serial bus lines (shift clock, data, register select, chip enable, reset)
// as seen by the capture block.
interface disp_serial_capture_if;
    logic disp_clock;
    logic disp_data_out;
    logic disp_rs;
    logic disp_ce_b;
    logic disp_reset_b;

    modport master (output disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b);
    modport slave  (input  disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b);
endinterface

// File: rtl/disp_serial_capture.sv
// Display serial bus capture: rebuilds the 640-bit dot register, control word and decoded hex nibbles.
// Optional latch bit-count check is built when DISP_CAPTURE_LEN_CHECK_EN is defined.
module disp_serial_capture (
    input  logic                 clock_27mhz,
    input  logic                 reset,
    disp_serial_capture_if.slave bus,
    input  logic [3:0]           char_sel,
    output logic [39:0]          char_dots,
    output logic [31:0]          ctrl_word,
    output logic                 ctrl_stb,
    output logic                 frame_stb,
    output logic [63:0]          hex_data,
    output logic [15:0]          hex_valid,
    output logic                 hex_stb,
    output logic                 len_err
);
    typedef enum logic {IDLE, DEC} state_t;

    // Sync bit order {reset_b, ce_b, rs, data, clock}; idle levels avoid a false latch out of reset.
    localparam logic [4:0] BUS_IDLE = 5'b11000;

    function automatic logic [39:0] hex_glyph(input logic [3:0] code);
        case (code)
            4'h0:    hex_glyph = 40'h3E_51_49_45_3E;
            4'h1:    hex_glyph = 40'h00_42_7F_40_00;
            4'h2:    hex_glyph = 40'h62_51_49_49_46;
            4'h3:    hex_glyph = 40'h22_41_49_49_36;
            4'h4:    hex_glyph = 40'h18_14_12_7F_10;
            4'h5:    hex_glyph = 40'h27_45_45_45_39;
            4'h6:    hex_glyph = 40'h3C_4A_49_49_30;
            4'h7:    hex_glyph = 40'h01_71_09_05_03;
            4'h8:    hex_glyph = 40'h36_49_49_49_36;
            4'h9:    hex_glyph = 40'h06_49_49_29_1E;
            4'hA:    hex_glyph = 40'h7E_09_09_09_7E;
            4'hB:    hex_glyph = 40'h7F_49_49_49_36;
            4'hC:    hex_glyph = 40'h3E_41_41_41_22;
            4'hD:    hex_glyph = 40'h7F_41_41_41_3E;
            4'hE:    hex_glyph = 40'h7F_49_49_49_41;
            default: hex_glyph = 40'h7F_09_09_09_01;
        endcase
    endfunction

    logic [4:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]   prev_q, prev_d;
    logic [639:0] shift_reg_q, shift_reg_d, dot_reg_q, dot_reg_d;
    logic [9:0]   bit_cnt_q, bit_cnt_d;
    logic         rs_lat_q, rs_lat_d;
    logic [31:0]  ctrl_word_q, ctrl_word_d;
    logic         ctrl_stb_q, ctrl_stb_d, frame_stb_q, frame_stb_d, hex_stb_q, hex_stb_d;
    logic [39:0]  char_dots_q, char_dots_d;
    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [63:0]  stage_data_q, stage_data_d, hex_data_q, hex_data_d;
    logic [15:0]  stage_valid_q, stage_valid_d, hex_valid_q, hex_valid_d;

    logic         dreset, ce_rise, ce_fall, clk_rise, shift_en, dot_latch, ctrl_latch;
    logic [39:0]  glyph;
    logic         glyph_hit;
    logic [3:0]   glyph_code;

    always_comb begin
        sync1_d = {bus.disp_reset_b, bus.disp_ce_b, bus.disp_rs, bus.disp_data_out, bus.disp_clock};
        sync2_d = sync1_q;
        prev_d  = {sync2_q[3], sync2_q[0]};

        dreset   = ~sync2_q[4];
        ce_rise  =  sync2_q[3] & ~prev_q[1];
        ce_fall  = ~sync2_q[3] &  prev_q[1];
        clk_rise =  sync2_q[0] & ~prev_q[0];
        // A clock edge coinciding with the ce_b rise still shifts before the latch.
        shift_en   = clk_rise & ~(sync2_q[3] & prev_q[1]);
        dot_latch  = ce_rise & ~rs_lat_q & ~dreset;
        ctrl_latch = ce_rise &  rs_lat_q & ~dreset;

        shift_reg_d = shift_en ? {shift_reg_q[638:0], sync2_q[1]} : shift_reg_q;
        bit_cnt_d   = ce_fall ? 10'd0 : bit_cnt_q;
        if (shift_en && bit_cnt_d != 10'd1023)
            bit_cnt_d = bit_cnt_d + 10'd1;
        rs_lat_d    = ce_fall ? sync2_q[2] : rs_lat_q;

        dot_reg_d   = dot_latch  ? shift_reg_d        : dot_reg_q;
        ctrl_word_d = ctrl_latch ? shift_reg_d[31:0]  : ctrl_word_q;
        frame_stb_d = dot_latch;
        ctrl_stb_d  = ctrl_latch;
        char_dots_d = dot_reg_q[10'(char_sel) * 10'd40 +: 40];

        glyph      = dot_reg_q[10'(idx_q) * 10'd40 +: 40];
        glyph_hit  = 1'b0;
        glyph_code = 4'h0;
        for (int g = 0; g < 16; g++) begin
            if (glyph == hex_glyph(4'(g))) begin
                glyph_hit  = 1'b1;
                glyph_code = 4'(g);
            end
        end

        state_d       = state_q;
        idx_d         = idx_q;
        stage_data_d  = stage_data_q;
        stage_valid_d = stage_valid_q;
        hex_data_d    = hex_data_q;
        hex_valid_d   = hex_valid_q;
        hex_stb_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_stb_q) begin
                    state_d = DEC;
                    idx_d   = 4'd15;
                end
            end
            DEC: begin
                stage_data_d[6'(idx_q) * 6'd4 +: 4] = glyph_hit ? glyph_code : 4'h0;
                stage_valid_d[idx_q]                 = glyph_hit;
                if (frame_stb_q) begin
                    idx_d = 4'd15;
                end else if (idx_q == 4'd0) begin
                    // Publish only complete results.
                    state_d     = IDLE;
                    hex_stb_d   = 1'b1;
                    hex_data_d  = stage_data_d;
                    hex_valid_d = stage_valid_d;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dreset) begin
            shift_reg_d   = '0;
            bit_cnt_d     = '0;
            dot_reg_d     = '0;
            ctrl_word_d   = '0;
            state_d       = IDLE;
            idx_d         = 4'd0;
            stage_valid_d = '0;
            hex_valid_d   = '0;
            hex_stb_d     = 1'b0;
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            sync1_q       <= BUS_IDLE;
            sync2_q       <= BUS_IDLE;
            prev_q        <= 2'b10;
            shift_reg_q   <= '0;
            dot_reg_q     <= '0;
            bit_cnt_q     <= '0;
            rs_lat_q      <= 1'b0;
            ctrl_word_q   <= '0;
            ctrl_stb_q    <= 1'b0;
            frame_stb_q   <= 1'b0;
            hex_stb_q     <= 1'b0;
            char_dots_q   <= '0;
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            stage_data_q  <= '0;
            stage_valid_q <= '0;
            hex_data_q    <= '0;
            hex_valid_q   <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            shift_reg_q   <= shift_reg_d;
            dot_reg_q     <= dot_reg_d;
            bit_cnt_q     <= bit_cnt_d;
            rs_lat_q      <= rs_lat_d;
            ctrl_word_q   <= ctrl_word_d;
            ctrl_stb_q    <= ctrl_stb_d;
            frame_stb_q   <= frame_stb_d;
            hex_stb_q     <= hex_stb_d;
            char_dots_q   <= char_dots_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            stage_data_q  <= stage_data_d;
            stage_valid_q <= stage_valid_d;
            hex_data_q    <= hex_data_d;
            hex_valid_q   <= hex_valid_d;
        end
    end

`ifdef DISP_CAPTURE_LEN_CHECK_EN
    logic len_err_q, len_err_d;

    // Sticky across display resets; only the system reset clears it.
    always_comb begin
        len_err_d = len_err_q;
        if ((dot_latch && bit_cnt_d != 10'd640) || (ctrl_latch && bit_cnt_d != 10'd32))
            len_err_d = 1'b1;
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) len_err_q <= 1'b0;
        else       len_err_q <= len_err_d;
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign char_dots = char_dots_q;
    assign ctrl_word = ctrl_word_q;
    assign ctrl_stb  = ctrl_stb_q;
    assign frame_stb = frame_stb_q;
    assign hex_data  = hex_data_q;
    assign hex_valid = hex_valid_q;
    assign hex_stb   = hex_stb_q;
endmodule

// File: doc/disp_serial_capture.md
# disp_serial_capture

Receiver for the four-chip, 16-character dot-matrix display serial bus. It sits on the bus lines disp_clock, disp_data_out, disp_rs, disp_ce_b and disp_reset_b, and reconstructs what the display latched: the 640-bit dot register, the 32-bit control word, and a recovered 16-nibble hex value. It is used as a loopback checker in simulation and on-board, and as a capture front end for logic-analyzer style debug of display traffic.

## Interface
- No parameters. Geometry is fixed: 16 chars × 40 dots = 640 dot bits, 32 control bits.
- clock_27mhz  in  1  system clock; bus lines are oversampled (bus clock is approx. 500 kHz).
- reset  in  1  synchronous, active-high.
- disp_clock  in  1  bus shift clock; data is sampled on its rising edge.
- disp_data_out  in  1  serial data, MSB first.
- disp_rs  in  1  register select: 0 = dot register, 1 = control register.
- disp_ce_b  in  1  chip enable, active low; its rising edge latches the shifted data.
- disp_reset_b  in  1  display reset, active low.
- char_sel  in  4  character index for the dot read port.
- char_dots  out  40  dots of char_sel; registered, 1-cycle latency.
- ctrl_word  out  32  last latched control word.
- ctrl_stb  out  1  1-cycle pulse when ctrl_word updates.
- frame_stb  out  1  1-cycle pulse when the dot register is latched.
- hex_data  out  64  recovered nibbles; char n maps to bits [4n+3:4n].
- hex_valid  out  16  bit n is set when char n matched a font glyph.
- hex_stb  out  1  1-cycle pulse when hex_data and hex_valid update.
- len_err  out  1  sticky flag for a latch with the wrong bit count (see Configuration).

## Operation
- All five bus inputs pass through 2-flop synchronizers. Edges are detected on the synchronized copies.
- Falling edge of ce_b:
  - bit_cnt (10-bit, saturates at 1023) clears to 0.
  - rs_lat captures the synchronized rs. The latched RS value is the one used at the latch; rs toggling at the ce_b rising edge is ignored.
- Rising edge of disp_clock while ce_b is low:
  - shift_reg (640 bits) shifts left; data_out enters at bit 0.
  - bit_cnt increments.
- Rising edge of ce_b:
  - rs_lat = 0: dot_reg <= shift_reg, then pulse frame_stb. dot_reg[639] is the first bit sent. Char n occupies dot_reg[40n+39:40n].
  - rs_lat = 1: ctrl_word <= shift_reg[31:0], then pulse ctrl_stb.
  - If fewer bits than the register width were shifted, the stale upper shift_reg bits are latched as-is.
- disp_reset_b low (synchronized):
  - Clears dot_reg, shift_reg and bit_cnt.
  - Sets ctrl_word to 0.
  - Aborts any decode. hex_valid <= 0.
  - No strobes fire.
- Decode FSM, triggered by frame_stb:
  - States are IDLE and DEC. On frame_stb the FSM enters DEC with idx = 15.
  - Each DEC cycle compares the 40-bit glyph of char idx against the team's standard 16-entry hex font, e.g. '0' = 40'h3E51_49453E, '1' = 40'h0042_7F4000.
    - On a match: nibble n <= glyph code, hex_valid[n] <= 1.
    - Otherwise: nibble n <= 0, hex_valid[n] <= 0.
  - After idx = 0 the FSM returns to IDLE and pulses hex_stb.
  - A new frame_stb during DEC restarts decode at idx = 15. Results are written to staging registers and transfer to hex_data/hex_valid only with hex_stb, so no partial update is ever visible.

## Timing
- Reset values:
  - char_dots, ctrl_word, hex_data, hex_valid = 0.
  - All strobes = 0. len_err = 0.
  - FSM in IDLE. dot_reg and shift_reg = 0.
- Pin-to-action latency:
  - A pin edge is acted on 3 clocks after it changes: 2 synchronizer stages plus 1 edge-detect stage.
  - frame_stb/ctrl_stb are asserted in the cycle after the ce_b rising edge is detected.
- Decode takes 16 DEC cycles. hex_stb is asserted 17 clocks after frame_stb.
- char_dots reflects the char_sel and dot_reg values of the previous cycle.
- Simultaneous edges on one clock:
  - ce_b rising and disp_clock rising: the shift happens first, then the latch.
  - Reset (either reset or disp_reset_b) has priority over everything.

## Configuration
- DISP_CAPTURE_LEN_CHECK_EN defined:
  - At each latch, len_err is set if bit_cnt != 640 for rs_lat = 0, or bit_cnt != 32 for rs_lat = 1.
  - len_err is cleared only by reset; disp_reset_b does not clear it.
- DISP_CAPTURE_LEN_CHECK_EN undefined: len_err is tied to 0 and no compare logic is built.

## Test plan
- Reset sequence, 640 zeros latched with rs = 0, then 32 bits of 0x7F7F7F7F latched with rs = 1, RS flipping high at the ce_b rise of the dot latch:
  - frame_stb pulses once with dot_reg all zero.
  - ctrl_word = 32'h7F7F7F7F, ctrl_stb pulses.
  - The zero frame decodes to hex_valid = 16'h0000.
- Frame encoding data 64'h0123456789ABCDEF, char 15 first, dot 39 first:
  - hex_stb pulses 17 clocks after frame_stb.
  - hex_data = 64'h0123456789ABCDEF, hex_valid = 16'hFFFF.
  - char_sel = 0 gives char_dots = the 'F' glyph one cycle later.
- Same frame with char 3 corrupted by one flipped dot: hex_valid = 16'hFFF7, and nibble 3 reads 0.
- Second frame latched 8 clocks into a decode: only one hex_stb, and it carries the second frame's value.
- 639-bit dot latch with the macro on: len_err = 1, and it stays set across a later correct frame. With the macro off, len_err stays 0.
- disp_reset_b pulsed low after a valid frame: ctrl_word = 0, hex_valid = 0, char_dots = 0 for every char_sel, no strobes.
